// File: rtl/lfsr_scrambler_n_pkg.sv
// Shared constants and helpers for the additive LFSR scrambler.
// Tap masks are Galois feedback values applied after a right shift.
package scrambler_pkg;

    localparam logic [3:0]  TAPS_W4  = 4'h9;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;

    // Bits needed to count 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lfsr_scrambler_n_if.sv
// Method-style EN_/RDY_ bundle for the scrambler.
// The master drives strobes and data; the slave is the scrambler itself.
interface lfsr_scrambler_n_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    import scrambler_pkg::*;

    localparam int OCC_W = occ_w(DEPTH);

    logic [WIDTH-1:0] in_data;
    logic             EN_in;
    logic             RDY_in;
    logic [WIDTH-1:0] seed_value;
    logic             EN_seed;
    logic             RDY_seed;
    logic             EN_out;
    logic [WIDTH-1:0] out;
    logic             RDY_out;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output in_data, EN_in, seed_value, EN_seed, EN_out,
        input  RDY_in, RDY_seed, out, RDY_out, occupancy
    );

    modport slave (
        input  in_data, EN_in, seed_value, EN_seed, EN_out,
        output RDY_in, RDY_seed, out, RDY_out, occupancy
    );

endinterface

// File: rtl/lfsr_scrambler_n_fifo.sv
// Synchronous FIFO buffering words ahead of the scrambler XOR.
// Full/empty come from the occupancy counter; strobes at full/empty are dropped.
module scrambler_fifo
    import scrambler_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      enq,
    input  logic [WIDTH-1:0]          enq_data,
    input  logic                      deq,
    output logic [WIDTH-1:0]          head,
    output logic                      full,
    output logic                      empty,
    output logic [occ_w(DEPTH)-1:0]   count
);

    localparam int OCC_W = occ_w(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             enq_ok;
    logic             deq_ok;

    assign full   = (count == OCC_FULL);
    assign empty  = (count == '0);
    assign enq_ok = enq & ~full;
    assign deq_ok = deq & ~empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (deq_ok) rd_ptr <= rd_ptr + PTR_ONE;
            case ({enq_ok, deq_ok})
                2'b10:   count <= count + OCC_ONE;
                2'b01:   count <= count - OCC_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: stale words are unreachable once pointers clear.
    always_ff @(posedge CLK) begin
        if (enq_ok) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/lfsr_scrambler_n.sv
// Additive scrambler: FIFO head XOR Galois LFSR, LFSR steps on each accepted pop.
// The same block with the same seed descrambles its own output.
module lfsr_scrambler_n
    import scrambler_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = TAPS_W8,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] SEED_RST = WIDTH'(1)
) (
    input logic             CLK,
    input logic             RST_N,
    lfsr_scrambler_n_if.slave bus
);

    logic [WIDTH-1:0]        lfsr;
    logic [WIDTH-1:0]        head;
    logic                    full;
    logic                    empty;
    logic [occ_w(DEPTH)-1:0] count;
    logic                    deq_ok;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // A zero seed would lock the LFSR at zero forever, so fall back to the reset seed.
    function automatic logic [WIDTH-1:0] seed_sel(input logic [WIDTH-1:0] s);
        return (s == '0) ? SEED_RST : s;
    endfunction

    scrambler_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .enq      (bus.EN_in),
        .enq_data (bus.in_data),
        .deq      (bus.EN_out),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign deq_ok = bus.EN_out & ~empty;

    always_ff @(posedge CLK) begin
        if (!RST_N)            lfsr <= SEED_RST;
        else if (bus.EN_seed)  lfsr <= seed_sel(bus.seed_value);
        else if (deq_ok)       lfsr <= lfsr_next(lfsr);
    end

    assign bus.out       = empty ? '0 : (head ^ lfsr);
    assign bus.RDY_in    = ~full;
    assign bus.RDY_out   = ~empty;
    assign bus.RDY_seed  = 1'b1;
    assign bus.occupancy = count;

endmodule

// File: tb/tb_lfsr_scrambler_n.sv
// Bench for lfsr_scrambler_n: queue scoreboard of buffered words plus a reference LFSR.
module tb_lfsr_scrambler_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_scrambler_n_if #(.WIDTH(8), .DEPTH(4)) ifa ();
    lfsr_scrambler_n_if #(.WIDTH(8), .DEPTH(4)) ifb ();

    lfsr_scrambler_n #(.WIDTH(8), .TAPS(8'hB8), .DEPTH(4), .SEED_RST(8'h01)) dut_a (
        .CLK(clk), .RST_N(rst_n), .bus(ifa)
    );
    lfsr_scrambler_n #(.WIDTH(8), .TAPS(8'hB8), .DEPTH(4), .SEED_RST(8'h01)) dut_b (
        .CLK(clk), .RST_N(rst_n), .bus(ifb)
    );

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] sb[$];
    logic [7:0] m_lfsr = 8'h01;

    function automatic logic [7:0] ref_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    task automatic idle_inputs();
        ifa.EN_in = 0; ifa.EN_out = 0; ifa.EN_seed = 0; ifa.in_data = '0; ifa.seed_value = '0;
        ifb.EN_in = 0; ifb.EN_out = 0; ifb.EN_seed = 0; ifb.in_data = '0; ifb.seed_value = '0;
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        m_lfsr = 8'h01;
    endtask

    // One cycle of stimulus on instance A; returns the sampled out and the scoreboard value.
    task automatic drive(input bit p, input logic [7:0] d, input bit o, input bit s,
                         input logic [7:0] sv, output logic [7:0] obs, output logic [7:0] exp);
        bit push_ok, pop_ok;
        logic [7:0] dropped;
        obs = ifa.out;
        push_ok = p && (sb.size() < 4);
        pop_ok  = o && (sb.size() > 0);
        exp = pop_ok ? (sb[0] ^ m_lfsr) : 8'h00;
        if (p && !push_ok) $display("protocol error: EN_in while full");
        if (o && !pop_ok)  $display("protocol error: EN_out while empty");
        ifa.EN_in = p; ifa.in_data = d; ifa.EN_out = o; ifa.EN_seed = s; ifa.seed_value = sv;
        @(negedge clk);
        ifa.EN_in = 0; ifa.EN_out = 0; ifa.EN_seed = 0;
        if (pop_ok) dropped = sb.pop_front();
        if (s) m_lfsr = (sv == 8'h00) ? 8'h01 : sv;
        else if (pop_ok) m_lfsr = ref_next(m_lfsr);
        if (push_ok) sb.push_back(d);
    endtask

    task automatic test_reset();
        logic [7:0] obs, exp;
        logic [7:0] req [3];
        req[0] = 8'h01; req[1] = 8'hB8; req[2] = 8'h5C;
        do_reset(2);
        if (ifa.RDY_in !== 1'b1) begin $display("FAIL reset_rdy_in: got %b want 1", ifa.RDY_in); n_mis++; end
        n_cmp++;
        if (ifa.RDY_out !== 1'b0) begin $display("FAIL reset_rdy_out: got %b want 0", ifa.RDY_out); n_mis++; end
        n_cmp++;
        if (ifa.out !== 8'h00) begin $display("FAIL reset_out: got %h want 00", ifa.out); n_mis++; end
        n_cmp++;
        if (ifa.occupancy !== 3'd0) begin $display("FAIL reset_occ: got %0d want 0", ifa.occupancy); n_mis++; end
        n_cmp++;
        if (ifa.RDY_seed !== 1'b1) begin $display("FAIL reset_rdy_seed: got %b want 1", ifa.RDY_seed); n_mis++; end
        n_cmp++;
        for (int i = 0; i < 3; i++) drive(1, 8'h00, 0, 0, 8'h00, obs, exp);
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 1, 0, 8'h00, obs, exp);
            if (obs !== req[i]) begin $display("FAIL reset_seq%0d: got %h want %h", i, obs, req[i]); n_mis++; end
            n_cmp++;
            if (obs !== exp) begin $display("FAIL reset_sb%0d: got %h want %h", i, obs, exp); n_mis++; end
            n_cmp++;
        end
    endtask

    task automatic test_zero_seed();
        logic [7:0] obs, exp;
        drive(0, 8'h00, 0, 1, 8'h00, obs, exp);
        drive(1, 8'h00, 0, 0, 8'h00, obs, exp);
        drive(0, 8'h00, 1, 0, 8'h00, obs, exp);
        if (obs !== 8'h01) begin $display("FAIL zero_seed: got %h want 01", obs); n_mis++; end
        n_cmp++;
        drive(0, 8'h00, 0, 1, 8'h5C, obs, exp);
        drive(1, 8'hFF, 0, 0, 8'h00, obs, exp);
        drive(0, 8'h00, 1, 0, 8'h00, obs, exp);
        if (obs !== 8'hA3) begin $display("FAIL seed_5c: got %h want a3", obs); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_full();
        logic [7:0] obs, exp;
        do_reset(1);
        for (int i = 0; i < 4; i++) drive(1, 8'($urandom), 0, 0, 8'h00, obs, exp);
        if (ifa.occupancy !== 3'd4) begin $display("FAIL full_occ: got %0d want 4", ifa.occupancy); n_mis++; end
        n_cmp++;
        if (ifa.RDY_in !== 1'b0) begin $display("FAIL full_rdy_in: got %b want 0", ifa.RDY_in); n_mis++; end
        n_cmp++;
        drive(1, 8'hEE, 0, 0, 8'h00, obs, exp);
        if (ifa.occupancy !== 3'd4) begin $display("FAIL full_drop_occ: got %0d want 4", ifa.occupancy); n_mis++; end
        n_cmp++;
        drive(0, 8'h00, 1, 0, 8'h00, obs, exp);
        if (obs !== exp) begin $display("FAIL full_pop: got %h want %h", obs, exp); n_mis++; end
        n_cmp++;
        if (ifa.RDY_in !== 1'b1) begin $display("FAIL full_pop_rdy_in: got %b want 1", ifa.RDY_in); n_mis++; end
        n_cmp++;
        drive(1, 8'($urandom), 1, 0, 8'h00, obs, exp);
        if (obs !== exp) begin $display("FAIL pushpop_out: got %h want %h", obs, exp); n_mis++; end
        n_cmp++;
        if (ifa.occupancy !== 3'd3) begin $display("FAIL pushpop_occ: got %0d want 3", ifa.occupancy); n_mis++; end
        n_cmp++;
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 1, 0, 8'h00, obs, exp);
            if (obs !== exp) begin $display("FAIL full_drain%0d: got %h want %h", i, obs, exp); n_mis++; end
            n_cmp++;
        end
        if (ifa.RDY_out !== 1'b0) begin $display("FAIL full_empty: got %b want 0", ifa.RDY_out); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_seed_pop();
        logic [7:0] obs, exp;
        do_reset(1);
        drive(1, 8'h00, 0, 0, 8'h00, obs, exp);
        drive(1, 8'h00, 0, 0, 8'h00, obs, exp);
        drive(0, 8'h00, 1, 1, 8'h33, obs, exp);
        if (obs !== 8'h01) begin $display("FAIL seedpop_cur: got %h want 01", obs); n_mis++; end
        n_cmp++;
        drive(0, 8'h00, 1, 0, 8'h00, obs, exp);
        if (obs !== 8'h33) begin $display("FAIL seedpop_next: got %h want 33", obs); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_round_trip();
        logic [7:0] obs, exp;
        logic [7:0] orig [64];
        logic [7:0] scr [64];
        do_reset(1);
        ifb.seed_value = 8'h21; ifb.EN_seed = 1;
        drive(0, 8'h00, 0, 1, 8'h21, obs, exp);
        ifb.EN_seed = 0;
        for (int i = 0; i < 64; i++) begin
            orig[i] = 8'($urandom);
            drive(1, orig[i], 0, 0, 8'h00, obs, exp);
            drive(0, 8'h00, 1, 0, 8'h00, obs, exp);
            scr[i] = obs;
            if (obs !== exp) begin $display("FAIL rt_scr%0d: got %h want %h", i, obs, exp); n_mis++; end
            n_cmp++;
        end
        for (int i = 0; i < 64; i++) begin
            ifb.in_data = scr[i]; ifb.EN_in = 1;
            @(negedge clk);
            ifb.EN_in = 0;
            obs = ifb.out;
            if (obs !== orig[i]) begin $display("FAIL rt_desc%0d: got %h want %h", i, obs, orig[i]); n_mis++; end
            n_cmp++;
            ifb.EN_out = 1;
            @(negedge clk);
            ifb.EN_out = 0;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] obs, exp;
        do_reset(1);
        for (int i = 0; i < 3; i++) drive(1, 8'h00, 0, 0, 8'h00, obs, exp);
        drive(0, 8'h00, 1, 0, 8'h00, obs, exp);
        if (ifa.occupancy !== 3'd2) begin $display("FAIL mid_pre_occ: got %0d want 2", ifa.occupancy); n_mis++; end
        n_cmp++;
        ifa.EN_out = 1;
        do_reset(1);
        if (ifa.occupancy !== 3'd0) begin $display("FAIL mid_occ: got %0d want 0", ifa.occupancy); n_mis++; end
        n_cmp++;
        if (ifa.RDY_out !== 1'b0) begin $display("FAIL mid_rdy_out: got %b want 0", ifa.RDY_out); n_mis++; end
        n_cmp++;
        if (ifa.out !== 8'h00) begin $display("FAIL mid_out: got %h want 00", ifa.out); n_mis++; end
        n_cmp++;
        drive(0, 8'h00, 1, 0, 8'h00, obs, exp);
        drive(1, 8'h00, 0, 0, 8'h00, obs, exp);
        drive(0, 8'h00, 1, 0, 8'h00, obs, exp);
        if (obs !== 8'h01) begin $display("FAIL mid_pop: got %h want 01", obs); n_mis++; end
        n_cmp++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (%0d compared)", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_zero_seed();
        test_full();
        test_seed_pop();
        test_round_trip();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lfsr_scrambler_n.md
# lfsr_scrambler_n

Parametrised additive scrambler: buffers incoming WIDTH-bit words in a small FIFO and, on each dequeue, XORs the head word with a Galois LFSR state, then advances the LFSR. It generalises the fixed 4-bit, single-register scrambler:
- configurable width, polynomial, buffer depth and reset seed;
- all-zero lock-up protection;
- occupancy reporting.

It uses the same method-style EN_/RDY_ handshakes, so it drops into the existing link datapath. The identical block with the same seed also acts as the descrambler.

## Interface
- WIDTH, 8, data and LFSR width (≥2)
- TAPS, 8'hB8, Galois feedback mask XORed after the right shift
- DEPTH, 4, input FIFO entries (power of 2, ≥2)
- SEED_RST, 8'h01, LFSR value after reset; must be non-zero
- CLK  in  1  clock; all state updates on its rising edge
- RST_N  in  1  reset, synchronous, active-low
- in_data  in  WIDTH  word to enqueue
- EN_in  in  1  enqueue strobe; legal only when RDY_in=1
- RDY_in  out  1  FIFO not full
- seed_value  in  WIDTH  new LFSR state
- EN_seed  in  1  load seed strobe
- RDY_seed  out  1  constant 1
- EN_out  in  1  dequeue strobe; legal only when RDY_out=1
- out  out  WIDTH  head ^ lfsr when RDY_out=1, else 0
- RDY_out  out  1  FIFO not empty
- occupancy  out  $clog2(DEPTH+1)  entries held

## Operation
- **LFSR advance:** next = lfsr[0] ? (lfsr>>1) ^ TAPS : lfsr>>1. The LFSR advances only on an accepted EN_out.
- **Seed load:**
  - EN_seed loads seed_value.
  - If seed_value==0, SEED_RST is loaded instead (lock-up protection).
  - EN_seed has priority over the advance when both occur in the same cycle.
  - In that case `out` for the cycle still uses the pre-load lfsr, and the FIFO still pops.
- **Enqueue:** EN_in && RDY_in writes in_data at the tail and increments occupancy.
- **Dequeue:** EN_out && RDY_out pops the head and decrements occupancy.
- **Simultaneous EN_in and EN_out:** occupancy is unchanged. This is legal whenever 0<occupancy<DEPTH, and also at occupancy==DEPTH-1.
- **Illegal strobes:** EN_in while full, and EN_out while empty, are ignored. Pointers, occupancy and lfsr are unchanged. The bench flags them as protocol errors.
- **Pointers:** log2(DEPTH) bits, wrapping modulo DEPTH. Full/empty are derived from occupancy.
- **Arithmetic:** all datapath operations are bitwise XOR at WIDTH; no carries.

## Timing
- **Reset** (RST_N=0 at a CLK edge): lfsr=SEED_RST, pointers=0, occupancy=0. Resulting outputs: RDY_in=1, RDY_out=0, out=0, RDY_seed=1. Reset overrides any concurrent EN_*.
- **Reset mid-operation:** buffered words are discarded; no partial pop.
- **Enqueue-to-visible latency:** 1 cycle. A word enqueued at edge n is presented on out/RDY_out after edge n.
- **Combinational paths:**
  - out, RDY_*, occupancy are functions of registered state only.
  - There is no combinational path from any input to any output.
- **Registered updates:** seed load and LFSR advance take effect at the edge; the new lfsr is reflected in out in the following cycle.
- **Throughput:** one word per cycle in and out sustained, when not empty/full.

## Structure
- **Package `scrambler_pkg`:**
  - named tap constants: TAPS_W4=4'h9, TAPS_W8=8'hB8, TAPS_W16=16'hB400;
  - occupancy-width helper function.
- **Sub-module `scrambler_fifo`** (parametrised WIDTH, DEPTH): synchronous FIFO with enq/deq/full/empty/count, same synchronous active-low reset.
- The top level holds the LFSR register, next-state function, seed mux and output XOR.

## Test plan
- **Reset defaults:** after reset, RDY_in=1, RDY_out=0, out=0, occupancy=0. Enqueue 8'h00 three times, then pop three times. Required: out = 8'h01, 8'hB8, 8'h5C.
- **Zero-seed protection:**
  - EN_seed with 8'h00, then enqueue/pop 8'h00 → out=8'h01.
  - EN_seed with 8'h5C, then enqueue/pop 8'hFF → out=8'hA3.
- **Full boundary:**
  - Enqueue 4 words (DEPTH=4) → occupancy=4, RDY_in=0; a further EN_in leaves contents intact.
  - Pop one → RDY_in=1.
  - Simultaneous push+pop at occupancy 3 → stays 3.
- **Seed and pop in the same cycle:** with lfsr=8'h01 and head 8'h00, assert EN_seed(8'h33) with EN_out.
  - Required: out=8'h01 that cycle.
  - Next pop of 8'h00 gives 8'h33.
- **Round trip:** two instances, same seed 8'h21. Scramble 64 random words, then feed the outputs through the second instance. Required: the originals, in order.
- **Reset mid-operation:** at occupancy=2 with lfsr advanced, pulse RST_N low for 1 cycle. Required: occupancy=0, RDY_out=0; next pop of 8'h00 gives 8'h01.
